// File: rtl/multichannel_parallel_fir.sv
// multichannel_parallel_fir
//   Time-interleaved multi-channel FIR. One shared coefficient bank, one
//   WINLEN-deep delay line per channel, and a fully parallel multiply/add
//   tree, so one sample per cycle from any channel is accepted.
//   Signed two's complement arithmetic. The output is a programmable bit
//   window of the ACCW-bit accumulator.
//
//   Build option: define MCFIR_SATURATE_EN to saturate the output window.
//   Without it, the window is a plain bit-slice truncation.
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   cfg_valid/busy  coefficient write handshake
//   cfg_addr/data   tap index / signed coefficient
//   fir_din_*       sample stream in (valid/busy, channel tag, sample)
//   fir_dout_*      result stream out (valid/busy, channel tag, result)
//
// Pipeline (a sample accepted at edge N is valid at the output after edge N+3)
//   edge N   : delay line of the channel is updated, tag captured (stage 0)
//   edge N+1 : per-tap products of the updated line (stage 1)
//   edge N+2 : adder tree sum (stage 2)
//   edge N+3 : windowed / saturated output register (stage 3)
//   The whole pipeline freezes while the output is valid and busy.
module multichannel_parallel_fir #(
    parameter int DWIDTH   = 8,
    parameter int CWIDTH   = 8,
    parameter int AWIDTH   = 4,
    parameter int WINLEN   = 12,
    parameter int CHANNELS = 4,
    parameter int CHWIDTH  = 2,
    parameter int OWIDTH   = 20,
    parameter int OSTART   = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_busy,
    input  logic [AWIDTH-1:0]   cfg_addr,
    input  logic [CWIDTH-1:0]   cfg_data,
    input  logic                fir_din_valid,
    output logic                fir_din_busy,
    input  logic [CHWIDTH-1:0]  fir_din_chan,
    input  logic [DWIDTH-1:0]   fir_din_data,
    output logic                fir_dout_valid,
    input  logic                fir_dout_busy,
    output logic [CHWIDTH-1:0]  fir_dout_chan,
    output logic [OWIDTH-1:0]   fir_dout_data
);

    localparam int ACCW = DWIDTH + CWIDTH + $clog2(WINLEN);

    logic signed [CWIDTH-1:0] r_coef [WINLEN];
    logic signed [DWIDTH-1:0] r_x    [CHANNELS][WINLEN];

    logic                     r_v0, r_v1, r_v2, r_v3;
    logic [CHWIDTH-1:0]       r_ch0, r_ch1, r_ch2, r_ch3;
    logic signed [ACCW-1:0]   r_prod [WINLEN];
    logic signed [ACCW-1:0]   r_sum;
    logic [OWIDTH-1:0]        r_dout;

    logic                     w_stall;
    logic                     w_din_acc;
    logic                     w_cfg_acc;
    logic                     w_chan_ok;
    logic signed [DWIDTH-1:0] w_xsel [WINLEN];
    logic signed [ACCW-1:0]   w_prod [WINLEN];
    logic signed [ACCW-1:0]   w_sum;
    logic [OWIDTH-1:0]        w_out;

    assign w_stall        = r_v3 & fir_dout_busy;
    assign cfg_busy       = r_v0 | r_v1 | r_v2 | r_v3;
    // Config wins over a sample in the same cycle.
    assign fir_din_busy   = w_stall | cfg_valid;
    assign w_din_acc      = fir_din_valid & ~fir_din_busy;
    assign w_cfg_acc      = cfg_valid & ~cfg_busy;

    assign fir_dout_valid = r_v3;
    assign fir_dout_chan  = r_ch3;
    assign fir_dout_data  = r_dout;

    // Out-of-range channels are accepted but never tracked.
    always_comb begin
        w_chan_ok = 1'b0;
        for (int unsigned c = 0; c < CHANNELS; c++)
            if (fir_din_chan == CHWIDTH'(c)) w_chan_ok = 1'b1;
    end

    // Coefficient bank; addresses >= WINLEN match no entry and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < WINLEN; k++) r_coef[k] <= '0;
        end else if (w_cfg_acc) begin
            for (int unsigned k = 0; k < WINLEN; k++)
                if (cfg_addr == AWIDTH'(k)) r_coef[k] <= cfg_data;
        end
    end

    // Per-channel delay lines (stage 0). w_din_acc already excludes stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < CHANNELS; c++)
                for (int unsigned k = 0; k < WINLEN; k++) r_x[c][k] <= '0;
        end else if (w_din_acc) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (fir_din_chan == CHWIDTH'(c)) begin
                    r_x[c][0] <= fir_din_data;
                    for (int unsigned k = 1; k < WINLEN; k++) r_x[c][k] <= r_x[c][k-1];
                end
            end
        end
    end

    // Products read the line of the stage-0 channel one edge after its
    // update; the line cannot move again meanwhile except by a newer sample,
    // whose update lands on the same edge these products are captured.
    always_comb begin
        for (int unsigned k = 0; k < WINLEN; k++) begin
            w_xsel[k] = '0;
            for (int unsigned c = 0; c < CHANNELS; c++)
                if (r_ch0 == CHWIDTH'(c)) w_xsel[k] = r_x[c][k];
            w_prod[k] = ACCW'(r_coef[k]) * ACCW'(w_xsel[k]);
        end
    end

    always_comb begin
        w_sum = '0;
        for (int unsigned k = 0; k < WINLEN; k++) w_sum = w_sum + r_prod[k];
    end

`ifdef MCFIR_SATURATE_EN
    logic [ACCW-OSTART-OWIDTH:0] w_hi;
    assign w_hi = r_sum[ACCW-1:OSTART+OWIDTH-1];

    // Overflow when the bits above the window are not a sign extension.
    always_comb begin
        w_out = r_sum[OSTART+OWIDTH-1:OSTART];
        if (!((&w_hi) || (~|w_hi))) begin
            if (r_sum[ACCW-1]) begin
                w_out             = '0;
                w_out[OWIDTH-1]   = 1'b1;
            end else begin
                w_out             = '1;
                w_out[OWIDTH-1]   = 1'b0;
            end
        end
    end
`else
    assign w_out = r_sum[OSTART+OWIDTH-1:OSTART];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v0   <= 1'b0;
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_v3   <= 1'b0;
            r_ch0  <= '0;
            r_ch1  <= '0;
            r_ch2  <= '0;
            r_ch3  <= '0;
            r_sum  <= '0;
            r_dout <= '0;
            for (int unsigned k = 0; k < WINLEN; k++) r_prod[k] <= '0;
        end else if (!w_stall) begin
            r_v0  <= w_din_acc & w_chan_ok;
            r_ch0 <= fir_din_chan;
            r_v1  <= r_v0;
            r_ch1 <= r_ch0;
            for (int unsigned k = 0; k < WINLEN; k++) r_prod[k] <= w_prod[k];
            r_v2  <= r_v1;
            r_ch2 <= r_ch1;
            r_sum <= w_sum;
            r_v3  <= r_v2;
            if (r_v2) begin
                r_ch3  <= r_ch2;
                r_dout <= w_out;
            end
        end
    end

endmodule

// File: tb/tb_multichannel_parallel_fir.sv
// Directed bench for multichannel_parallel_fir. Two instances share all
// inputs: the default build (OWIDTH=20) and a narrow one (OWIDTH=8) used to
// observe truncation or saturation (MCFIR_SATURATE_EN).
module tb_multichannel_parallel_fir;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [7:0]  cfg_data = '0;
    logic        fir_din_valid = 1'b0;
    logic [1:0]  fir_din_chan = '0;
    logic [7:0]  fir_din_data = '0;
    logic        fir_dout_busy = 1'b0;

    logic        cfg_busy, fir_din_busy, fir_dout_valid;
    logic [1:0]  fir_dout_chan;
    logic [19:0] fir_dout_data;

    logic        n_cfg_busy, n_din_busy, n_dout_valid;
    logic [1:0]  n_dout_chan;
    logic [7:0]  n_dout_data;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  ch;
        logic [19:0] d;
        logic [7:0]  d8;
    } res_t;
    res_t q[$];

`ifdef MCFIR_SATURATE_EN
    localparam logic [7:0] EXP8_FULL = 8'h7F;
    localparam logic [7:0] EXP8_ONE  = 8'h7F;
    localparam logic [7:0] EXP8_NEG  = 8'h7F;
`else
    localparam logic [7:0] EXP8_FULL = 8'h0C;
    localparam logic [7:0] EXP8_ONE  = 8'h01;
    localparam logic [7:0] EXP8_NEG  = 8'h80;
`endif

    always #5 clk = ~clk;

    multichannel_parallel_fir u_dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_busy(cfg_busy),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .fir_din_valid(fir_din_valid), .fir_din_busy(fir_din_busy),
        .fir_din_chan(fir_din_chan), .fir_din_data(fir_din_data),
        .fir_dout_valid(fir_dout_valid), .fir_dout_busy(fir_dout_busy),
        .fir_dout_chan(fir_dout_chan), .fir_dout_data(fir_dout_data)
    );

    multichannel_parallel_fir #(.OWIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_busy(n_cfg_busy),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .fir_din_valid(fir_din_valid), .fir_din_busy(n_din_busy),
        .fir_din_chan(fir_din_chan), .fir_din_data(fir_din_data),
        .fir_dout_valid(n_dout_valid), .fir_dout_busy(fir_dout_busy),
        .fir_dout_chan(n_dout_chan), .fir_dout_data(n_dout_data)
    );

    // Output monitor: records every transfer just after the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && fir_dout_valid && !fir_dout_busy)
                q.push_back('{fir_dout_chan, fir_dout_data, n_dout_data});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // All stimulus tasks enter and leave on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cfg_valid = 1'b0;
        fir_din_valid = 1'b0;
        fir_dout_busy = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        q.delete();
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        #1;
        for (int i = 0; i < 50 && cfg_busy; i++) begin
            @(negedge clk);
            #1;
        end
        if (cfg_busy) begin
            n_cmp++; n_err++;
            $display("FAIL cfg_write_timeout: cfg_busy=%b required 0", cfg_busy);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic fill_coefs(input logic [7:0] v);
        for (int k = 0; k < 12; k++) cfg_write(4'(k), v);
    endtask

    task automatic send(input logic [1:0] ch, input logic [7:0] d);
        fir_din_valid = 1'b1;
        fir_din_chan  = ch;
        fir_din_data  = d;
        #1;
        for (int i = 0; i < 50 && fir_din_busy; i++) begin
            @(negedge clk);
            #1;
        end
        if (fir_din_busy) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: fir_din_busy=%b required 0", fir_din_busy);
        end
        @(negedge clk);
        fir_din_valid = 1'b0;
    endtask

    task automatic wait_results(input int n);
        for (int i = 0; i < 200 && q.size() < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_cmp++; if (fir_dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", fir_dout_valid); end
        n_cmp++; if (fir_dout_chan !== 2'd0) begin n_err++; $display("FAIL reset_chan: got %0d want 0", fir_dout_chan); end
        n_cmp++; if (fir_dout_data !== 20'h0) begin n_err++; $display("FAIL reset_data: got %h want 00000", fir_dout_data); end
        n_cmp++; if (cfg_busy !== 1'b0) begin n_err++; $display("FAIL reset_cfg_busy: got %b want 0", cfg_busy); end
        n_cmp++; if (fir_din_busy !== 1'b0) begin n_err++; $display("FAIL reset_din_busy: got %b want 0", fir_din_busy); end
        do_reset();
    endtask

    task automatic test_impulse();
        do_reset();
        cfg_write(4'd0, 8'd1);
        send(2'd0, 8'd5);
        // Accepted on the previous rising edge (N); valid only after N+3.
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (fir_dout_valid !== 1'b0) begin n_err++; $display("FAIL impulse_early: valid=%b want 0", fir_dout_valid); end
        @(negedge clk);
        #1;
        n_cmp++; if (fir_dout_valid !== 1'b1) begin n_err++; $display("FAIL impulse_latency: valid=%b want 1", fir_dout_valid); end
        n_cmp++; if (fir_dout_chan !== 2'd0) begin n_err++; $display("FAIL impulse_chan: got %0d want 0", fir_dout_chan); end
        n_cmp++; if (fir_dout_data !== 20'h00005) begin n_err++; $display("FAIL impulse_data: got %h want 00005", fir_dout_data); end
        @(negedge clk);
    endtask

    task automatic test_channel_isolation();
        logic [1:0]  ech [4] = '{2'd0, 2'd1, 2'd1, 2'd0};
        logic [19:0] edat[4] = '{20'd1, 20'd2, 20'd4, 20'd1};
        do_reset();
        fill_coefs(8'd1);
        send(2'd0, 8'd1);
        send(2'd1, 8'd2);
        send(2'd1, 8'd2);
        send(2'd0, 8'd0);
        wait_results(4);
        n_cmp++; if (q.size() !== 4) begin n_err++; $display("FAIL iso_count: got %0d want 4", q.size()); end
        for (int i = 0; i < 4 && i < q.size(); i++) begin
            n_cmp++;
            if (q[i].ch !== ech[i] || q[i].d !== edat[i]) begin
                n_err++;
                $display("FAIL iso_result%0d: got ch%0d/%0d want ch%0d/%0d", i, q[i].ch, q[i].d, ech[i], edat[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        fill_coefs(8'd1);
        fork
            begin
                for (int i = 0; i < 8; i++) send(2'd2, 8'd3);
            end
            begin
                repeat (4) @(negedge clk);
                fir_dout_busy = 1'b1;
                #1;
                n_cmp++; if (fir_din_busy !== 1'b1) begin n_err++; $display("FAIL bp_din_busy: got %b want 1", fir_din_busy); end
                repeat (3) @(negedge clk);
                #1;
                n_cmp++; if (fir_dout_valid !== 1'b1 || fir_din_busy !== 1'b1) begin
                    n_err++; $display("FAIL bp_frozen: valid=%b din_busy=%b want 1/1", fir_dout_valid, fir_din_busy);
                end
                repeat (2) @(negedge clk);
                fir_dout_busy = 1'b0;
            end
        join
        wait_results(8);
        n_cmp++; if (q.size() !== 8) begin n_err++; $display("FAIL bp_count: got %0d want 8", q.size()); end
        for (int i = 0; i < 8 && i < q.size(); i++) begin
            n_cmp++;
            if (q[i].ch !== 2'd2 || q[i].d !== 20'(3 * (i + 1))) begin
                n_err++;
                $display("FAIL bp_result%0d: got ch%0d/%0d want ch2/%0d", i, q[i].ch, q[i].d, 3 * (i + 1));
            end
        end
    endtask

    task automatic test_config_arbitration();
        int n;
        do_reset();
        cfg_write(4'd0, 8'd1);
        send(2'd0, 8'd7);
        cfg_valid = 1'b1;
        cfg_addr  = 4'd1;
        cfg_data  = 8'd2;
        #1;
        n_cmp++; if (cfg_busy !== 1'b1) begin n_err++; $display("FAIL arb_cfg_busy: got %b want 1", cfg_busy); end
        n_cmp++; if (fir_din_busy !== 1'b1) begin n_err++; $display("FAIL arb_din_busy_cfg: got %b want 1", fir_din_busy); end
        n = 0;
        while (cfg_busy && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        n_cmp++; if (n !== 4) begin n_err++; $display("FAIL arb_drain_cycles: got %0d want 4", n); end
        @(negedge clk);
        // Same-cycle cfg and sample on an idle pipeline; addr 13 is out of range.
        cfg_valid     = 1'b1;
        cfg_addr      = 4'd13;
        cfg_data      = 8'd5;
        fir_din_valid = 1'b1;
        fir_din_chan  = 2'd1;
        fir_din_data  = 8'd3;
        #1;
        n_cmp++; if (fir_din_busy !== 1'b1 || cfg_busy !== 1'b0) begin
            n_err++; $display("FAIL arb_same_cycle: din_busy=%b cfg_busy=%b want 1/0", fir_din_busy, cfg_busy);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        #1;
        n_cmp++; if (fir_din_busy !== 1'b0) begin n_err++; $display("FAIL arb_din_next: got %b want 0", fir_din_busy); end
        @(negedge clk);
        fir_din_valid = 1'b0;
        send(2'd1, 8'd4);
        wait_results(3);
        n_cmp++; if (q.size() !== 3) begin n_err++; $display("FAIL arb_count: got %0d want 3", q.size()); end
        if (q.size() == 3) begin
            n_cmp++; if (q[0].ch !== 2'd0 || q[0].d !== 20'd7) begin n_err++; $display("FAIL arb_r0: got ch%0d/%0d want ch0/7", q[0].ch, q[0].d); end
            n_cmp++; if (q[1].ch !== 2'd1 || q[1].d !== 20'd3) begin n_err++; $display("FAIL arb_r1: got ch%0d/%0d want ch1/3", q[1].ch, q[1].d); end
            n_cmp++; if (q[2].ch !== 2'd1 || q[2].d !== 20'd10) begin n_err++; $display("FAIL arb_r2: got ch%0d/%0d want ch1/10", q[2].ch, q[2].d); end
        end
    endtask

    task automatic test_signed_window();
        do_reset();
        fill_coefs(8'd127);
        for (int i = 0; i < 12; i++) send(2'd3, 8'd127);
        wait_results(12);
        n_cmp++; if (q.size() !== 12) begin n_err++; $display("FAIL sat_count: got %0d want 12", q.size()); end
        if (q.size() == 12) begin
            n_cmp++; if (q[0].d !== 20'h03F01) begin n_err++; $display("FAIL sat_first20: got %h want 03F01", q[0].d); end
            n_cmp++; if (q[0].d8 !== EXP8_ONE) begin n_err++; $display("FAIL sat_first8: got %h want %h", q[0].d8, EXP8_ONE); end
            n_cmp++; if (q[11].ch !== 2'd3 || q[11].d !== 20'h2F40C) begin n_err++; $display("FAIL sat_full20: got ch%0d/%h want ch3/2f40c", q[11].ch, q[11].d); end
            n_cmp++; if (q[11].d8 !== EXP8_FULL) begin n_err++; $display("FAIL sat_full8: got %h want %h", q[11].d8, EXP8_FULL); end
        end
        do_reset();
        cfg_write(4'd0, 8'hFF);
        send(2'd0, 8'h80);
        wait_results(1);
        n_cmp++; if (q.size() !== 1) begin n_err++; $display("FAIL neg_count: got %0d want 1", q.size()); end
        if (q.size() == 1) begin
            n_cmp++; if (q[0].d !== 20'h00080) begin n_err++; $display("FAIL neg_data20: got %h want 00080", q[0].d); end
            n_cmp++; if (q[0].d8 !== EXP8_NEG) begin n_err++; $display("FAIL neg_data8: got %h want %h", q[0].d8, EXP8_NEG); end
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        cfg_write(4'd0, 8'd1);
        send(2'd0, 8'd5);
        send(2'd0, 8'd6);
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (fir_dout_valid !== 1'b1 || fir_dout_data !== 20'd5) begin
            n_err++; $display("FAIL mid_pre: valid=%b data=%0d want 1/5", fir_dout_valid, fir_dout_data);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (fir_dout_valid !== 1'b0 || cfg_busy !== 1'b0) begin
            n_err++; $display("FAIL mid_reset: valid=%b cfg_busy=%b want 0/0", fir_dout_valid, cfg_busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        repeat (6) @(negedge clk);
        n_cmp++; if (q.size() !== 0) begin n_err++; $display("FAIL mid_no_output: got %0d results want 0", q.size()); end
        send(2'd0, 8'd9);
        wait_results(1);
        n_cmp++; if (q.size() !== 1) begin n_err++; $display("FAIL mid_count: got %0d want 1", q.size()); end
        if (q.size() == 1) begin
            n_cmp++; if (q[0].ch !== 2'd0 || q[0].d !== 20'd0) begin n_err++; $display("FAIL mid_coef_cleared: got ch%0d/%0d want ch0/0", q[0].ch, q[0].d); end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_channel_isolation();
        test_backpressure();
        test_config_arbitration();
        test_signed_window();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
